// File: rtl/sd_pkg.sv
// Shared types and constants for the SD CMD-line sequencer.
package sd_pkg;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_R1   = 2'd1,
    RESP_R2   = 2'd2,
    RESP_R3   = 2'd3
  } resp_type_e;

  typedef enum logic [2:0] {
    ST_POWERUP   = 3'd0,
    ST_IDLE      = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_RECV      = 3'd4,
    ST_TRAIL     = 3'd5,
    ST_DONE      = 3'd6
  } sd_state_e;

  localparam int CMD_LEN = 48;
  localparam int R2_LEN  = 136;
  localparam int NCC     = 8;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSB-first data, synchronous clear.
module sd_crc7 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic fb;
  assign fb = din ^ crc[6];

  // Feeding din = crc[6] makes fb zero, so the register shifts its value out MSB first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  crc <= 7'd0;
    else if (clr)  crc <= 7'd0;
    else if (en)   crc <= {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  end

endmodule

// File: rtl/sd_cmd_ctrl.sv
// SD CMD-line engine: clock generation, power-up train, command TX with CRC7,
// response capture and checking.
module sd_cmd_ctrl
  import sd_pkg::*;
#(
  parameter int CLK_DIV      = 63,
  parameter int RESP_TIMEOUT = 64,
  parameter int POWERUP_CLKS = 80
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   resp_type,
  output logic         busy,
  output logic         done,
  output logic         timeout_err,
  output logic         crc_err,
  output logic         end_err,
  output logic [5:0]   resp_index,
  output logic [127:0] resp,
  output logic         sd_clk,
  output logic         sd_cmd_out,
  output logic         sd_cmd_oe,
  input  logic         sd_cmd_in,
  output logic         sd_cmd_dir,
  output sd_state_e    dbg_state
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Handshake: start is honoured only in a cycle where busy is low; busy then
  // stays high until the cycle after the single-cycle done pulse.
  sd_state_e        state, state_next;
  logic [DIV_W-1:0] div_cnt;
  logic             sd_clk_r, rise_stb, fall_stb, clk_run;
  logic [15:0]      cnt, rx_need;
  logic [38:0]      tx_sh;
  logic             cmd_out_r, tx_bit, accept;
  logic [127:0]     rx_sh;
  resp_type_e       rt;
  logic             crc_clr, crc_en, crc_din;
  logic [6:0]       crc;

  assign accept  = (state == ST_IDLE) && start;
  assign rx_need = (rt == RESP_R2) ? 16'(R2_LEN - 1) : 16'(CMD_LEN - 1);
  // cnt is the index of the bit on the line; tx_bit is the one that follows it.
  assign tx_bit  = (cnt < 16'd39) ? tx_sh[38] : (cnt < 16'd46) ? crc[6] : 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_POWERUP;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_POWERUP:   if (fall_stb && cnt == 16'(POWERUP_CLKS - 1)) state_next = ST_IDLE;
      ST_IDLE:      if (start) state_next = ST_SEND;
      ST_SEND:      if (fall_stb && cnt == 16'(CMD_LEN - 1))
                      state_next = (rt == RESP_NONE) ? ST_TRAIL : ST_WAIT_RESP;
      ST_WAIT_RESP: if (rise_stb && !sd_cmd_in) state_next = ST_RECV;
                    else if (fall_stb && cnt == 16'(RESP_TIMEOUT - 1)) state_next = ST_TRAIL;
      ST_RECV:      if (fall_stb && cnt == rx_need) state_next = ST_TRAIL;
      ST_TRAIL:     if (fall_stb && cnt == 16'(NCC - 1)) state_next = ST_DONE;
      ST_DONE:      state_next = ST_IDLE;
      default:      state_next = ST_POWERUP;
    endcase
  end

  always_comb begin
    busy       = 1'b1;
    done       = 1'b0;
    clk_run    = 1'b0;
    sd_cmd_oe  = 1'b1;
    sd_cmd_out = 1'b1;
    case (state)
      ST_POWERUP:            clk_run = 1'b1;
      ST_IDLE:               busy = 1'b0;
      ST_SEND:               begin clk_run = 1'b1; sd_cmd_out = cmd_out_r; end
      ST_WAIT_RESP, ST_RECV: begin clk_run = 1'b1; sd_cmd_oe = 1'b0; end
      ST_TRAIL:              clk_run = 1'b1;
      ST_DONE:               done = 1'b1;
      default:               ;
    endcase
  end

  assign sd_cmd_dir = sd_cmd_oe;
  assign sd_clk     = sd_clk_r;
  assign dbg_state  = state;

  // Strobes are registered alongside sd_clk, so they mark the cycle the pad edge appears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      sd_clk_r <= 1'b0;
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
    end else if (!clk_run) begin
      div_cnt  <= '0;
      sd_clk_r <= 1'b0;
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
    end else if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
      div_cnt  <= '0;
      sd_clk_r <= ~sd_clk_r;
      rise_stb <= ~sd_clk_r;
      fall_stb <= sd_clk_r;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      tx_sh       <= '0;
      cmd_out_r   <= 1'b1;
      rx_sh       <= '0;
      rt          <= RESP_NONE;
      timeout_err <= 1'b0;
      crc_err     <= 1'b0;
      end_err     <= 1'b0;
      resp_index  <= '0;
      resp        <= '0;
    end else begin
      if (state_next != state)
        cnt <= '0;
      else if ((state == ST_RECV) ? rise_stb : fall_stb)
        cnt <= cnt + 1'b1;

      if (accept) begin
        rt          <= resp_type_e'(resp_type);
        tx_sh       <= {1'b1, cmd_index, cmd_arg};
        cmd_out_r   <= 1'b0;
        timeout_err <= 1'b0;
        crc_err     <= 1'b0;
        end_err     <= 1'b0;
        resp_index  <= '0;
        resp        <= '0;
      end

      if (state == ST_SEND && fall_stb && cnt != 16'(CMD_LEN - 1)) begin
        cmd_out_r <= tx_bit;
        if (cnt < 16'd39) tx_sh <= {tx_sh[37:0], 1'b0};
      end

      if (state == ST_WAIT_RESP && state_next == ST_TRAIL)
        timeout_err <= 1'b1;

      if (state == ST_RECV && rise_stb)
        rx_sh <= {rx_sh[126:0], sd_cmd_in};

      if (state == ST_RECV && state_next == ST_TRAIL) begin
        if (rt == RESP_R2) begin
          resp       <= rx_sh;
          resp_index <= '0;
        end else begin
          resp       <= {96'h0, rx_sh[39:8]};
          resp_index <= rx_sh[45:40];
          crc_err    <= (rt == RESP_R1) && (crc != rx_sh[7:1]);
        end
        end_err <= ~rx_sh[0];
      end
    end
  end

  // The CRC unit follows TX bits during SEND and RX bits 46:8 during RECV.
  always_comb begin
    crc_clr = accept || (state == ST_SEND && state_next != ST_SEND);
    crc_en  = 1'b0;
    crc_din = 1'b0;
    if (state == ST_SEND && fall_stb && cnt < 16'(CMD_LEN - 2)) begin
      crc_en  = 1'b1;
      crc_din = tx_bit;
    end else if (state == ST_RECV && rise_stb && cnt < 16'd39) begin
      crc_en  = 1'b1;
      crc_din = sd_cmd_in;
    end
  end

  sd_crc7 u_crc (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (crc_clr),
    .en      (crc_en),
    .din     (crc_din),
    .crc     (crc)
  );

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// Bench for sd_cmd_ctrl: host-side driver, card model on the CMD line, and
// queues of expected TX frames and transaction results.
module tb_sd_cmd_ctrl;
  import sd_pkg::*;

  localparam int RW = 137;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic         start;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic [1:0]   resp_type;
  logic         busy, done, timeout_err, crc_err, end_err;
  logic [5:0]   resp_index;
  logic [127:0] resp;
  logic         sd_clk, sd_cmd_out, sd_cmd_oe, sd_cmd_in, sd_cmd_dir;
  sd_state_e    dbg_state;

  sd_cmd_ctrl #(.CLK_DIV(2), .RESP_TIMEOUT(64), .POWERUP_CLKS(80)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .cmd_index   (cmd_index),
    .cmd_arg     (cmd_arg),
    .resp_type   (resp_type),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .crc_err     (crc_err),
    .end_err     (end_err),
    .resp_index  (resp_index),
    .resp        (resp),
    .sd_clk      (sd_clk),
    .sd_cmd_out  (sd_cmd_out),
    .sd_cmd_oe   (sd_cmd_oe),
    .sd_cmd_in   (sd_cmd_in),
    .sd_cmd_dir  (sd_cmd_dir),
    .dbg_state   (dbg_state)
  );

  // scoreboard state
  logic [RW-1:0] exp_q[$];
  logic [47:0]   exp_tx_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] pack(input logic t, input logic c, input logic e,
                                         input logic [5:0] i, input logic [127:0] r);
    return {t, c, e, i, r};
  endfunction

  function automatic logic [8:0] ctl_vec();
    return {busy, sd_clk, sd_cmd_out, sd_cmd_oe, sd_cmd_dir, done, timeout_err, crc_err, end_err};
  endfunction

  // card model
  logic         card_drv, card_bit, card_en;
  logic [135:0] card_resp;
  int           card_len;
  event         resp_go;
  assign sd_cmd_in = card_drv ? card_bit : 1'b1;

  initial begin : card
    card_drv = 1'b0;
    card_bit = 1'b1;
    forever begin
      @(resp_go);
      repeat (2) @(negedge sd_clk);
      card_drv = 1'b1;
      for (int i = card_len - 1; i >= 0; i--) begin
        card_bit = card_resp[i];
        @(negedge sd_clk);
      end
      card_drv = 1'b0;
    end
  end

  // monitor: host TX frames
  initial begin : tx_mon
    logic [47:0] cap;
    forever begin
      @(posedge sd_clk);
      if (sd_cmd_oe === 1'b1 && sd_cmd_out === 1'b0) begin
        cap = 48'h0;
        for (int i = 1; i < 48; i++) begin
          @(posedge sd_clk);
          cap = {cap[46:0], sd_cmd_out};
        end
        if (exp_tx_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_tx_frame: got %h expected none", cap);
        end else begin
          chk("tx_frame", RW'(cap), RW'(exp_tx_q.pop_front()));
        end
        if (card_en) -> resp_go;
      end
    end
  end

  // monitor: transaction results on done
  initial begin : res_mon
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_done: got done expected none");
        end else begin
          chk("result", pack(timeout_err, crc_err, end_err, resp_index, resp), exp_q.pop_front());
        end
        chk("busy_at_done", RW'(busy), RW'(1));
      end
    end
  end

  // side monitors
  logic pu_mon = 1'b0;
  int   pu_rises = 0, pu_bad = 0, oe0_rises = 0, dir_bad = 0;

  initial forever begin
    @(posedge sd_clk);
    if (pu_mon) begin
      pu_rises++;
      if (!(sd_cmd_out && sd_cmd_oe && busy)) pu_bad++;
    end
  end

  initial forever begin
    @(posedge sd_clk);
    if (sd_cmd_oe === 1'b0) oe0_rises++;
  end

  initial forever begin
    @(negedge clk);
    if (sd_cmd_dir !== sd_cmd_oe) dir_bad++;
  end

  // driver tasks
  task automatic set_card(input logic en, input int len, input logic [135:0] data);
    card_en   = en;
    card_len  = len;
    card_resp = data;
  endtask

  task automatic issue(input logic [5:0] i, input logic [31:0] a, input logic [1:0] t,
                       input logic [47:0] tx, input logic push_res, input logic [RW-1:0] res);
    exp_tx_q.push_back(tx);
    if (push_res) exp_q.push_back(res);
    @(negedge clk);
    cmd_index = i;
    cmd_arg   = a;
    resp_type = t;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    int c = 0;
    while (busy && c < max_cycles) begin
      @(negedge clk);
      c++;
    end
    if (busy) begin
      n_cmp++; n_err++;
      $display("FAIL %s: got busy after %0d cycles expected idle", name, max_cycles);
    end
  endtask

  localparam logic [127:0] R2_BODY = 128'h1122_3344_5566_7788_99AA_BBCC_DDEE_FF01;

  initial begin : main
    int base;
    int c;
    reset_n   = 1'b0;
    start     = 1'b0;
    cmd_index = '0;
    cmd_arg   = '0;
    resp_type = '0;
    set_card(1'b0, 48, '0);

    repeat (3) @(negedge clk);
    chk("reset_ctl", RW'(ctl_vec()), RW'(9'b101110000));
    chk("reset_resp", RW'({resp_index, resp}), RW'(0));

    // power-up clock train
    pu_mon  = 1'b1;
    reset_n = 1'b1;
    wait_idle("powerup_idle", 2000);
    repeat (20) @(negedge clk);
    pu_mon = 1'b0;
    chk("powerup_rises", RW'(pu_rises), RW'(80));
    chk("powerup_line", RW'(pu_bad), RW'(0));
    chk("idle_clk_low", RW'({sd_clk, busy}), RW'(0));

    // CMD0, no response
    set_card(1'b0, 48, '0);
    issue(6'd0, 32'h0, 2'd0, 48'h400000000095, 1'b1, pack(0, 0, 0, 6'd0, 128'h0));
    wait_idle("cmd0_idle", 3000);

    // CMD8 R1, good reply
    set_card(1'b1, 48, 136'h08000001AA13);
    issue(6'd8, 32'h1AA, 2'd1, 48'h48000001AA87, 1'b1, pack(0, 0, 0, 6'd8, 128'h1AA));
    wait_idle("cmd8_idle", 3000);

    // CMD8 R1, one arg bit flipped by the card
    set_card(1'b1, 48, 136'h08000001AB13);
    issue(6'd8, 32'h1AA, 2'd1, 48'h48000001AA87, 1'b1, pack(0, 1, 0, 6'd8, 128'h1AB));
    wait_idle("crc_idle", 3000);

    // CMD8 R1, end bit 0
    set_card(1'b1, 48, 136'h08000001AA12);
    issue(6'd8, 32'h1AA, 2'd1, 48'h48000001AA87, 1'b1, pack(0, 0, 1, 6'd8, 128'h1AA));
    wait_idle("end_idle", 3000);

    // same bad-CRC reply as R3: CRC is not checked
    set_card(1'b1, 48, 136'h08000001AB13);
    issue(6'd8, 32'h1AA, 2'd3, 48'h48000001AA87, 1'b1, pack(0, 0, 0, 6'd8, 128'h1AB));
    wait_idle("r3_idle", 3000);

    // silent card: timeout, plus an ignored start while busy
    set_card(1'b0, 48, '0);
    base = oe0_rises;
    issue(6'd8, 32'h1AA, 2'd1, 48'h48000001AA87, 1'b1, pack(1, 0, 0, 6'd0, 128'h0));
    repeat (250) @(negedge clk);
    chk("busy_mid_txn", RW'(busy), RW'(1));
    cmd_index = 6'h3F;
    cmd_arg   = 32'hFFFF_FFFF;
    resp_type = 2'd0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("timeout_idle", 3000);
    chk("timeout_sd_clks", RW'(oe0_rises - base), RW'(64));

    // CMD2 R2
    set_card(1'b1, 136, {8'h3F, R2_BODY});
    issue(6'd2, 32'h0, 2'd2, 48'h42000000004D, 1'b1, pack(0, 0, 0, 6'd0, R2_BODY));
    wait_idle("r2_idle", 4000);

    // CMD2 R2 again, reset during RECV
    issue(6'd2, 32'h0, 2'd2, 48'h42000000004D, 1'b0, '0);
    c = 0;
    while (dbg_state != ST_RECV && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk("reached_recv", RW'(dbg_state == ST_RECV), RW'(1));
    repeat (60) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_ctl", RW'(ctl_vec()), RW'(9'b101110000));
    chk("midrst_resp", RW'({resp_index, resp}), RW'(0));
    chk("midrst_state", RW'(dbg_state), RW'(ST_POWERUP));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_idle("midrst_powerup", 2000);

    // recovery transaction
    set_card(1'b0, 48, '0);
    issue(6'd0, 32'h0, 2'd0, 48'h400000000095, 1'b1, pack(0, 0, 0, 6'd0, 128'h0));
    wait_idle("final_idle", 3000);
    repeat (40) @(negedge clk);

    chk("results_left", RW'(exp_q.size()), RW'(0));
    chk("tx_frames_left", RW'(exp_tx_q.size()), RW'(0));
    chk("dir_equals_oe", RW'(dir_bad), RW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
